// File: rtl/l2_cache_control.sv
// Sequencing FSM for the 2-way, 16-set write-back L2 cache: drives the array write
// strobes from the tag-compare results and keeps saturating hit/miss/writeback counters.
module l2_cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 l1_read,
    input  logic                 l1_write,
    output logic                 l1_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic                 hit0,
    input  logic                 hit1,
    input  logic                 dirty0,
    input  logic                 dirty1,
    input  logic                 lru,
    output logic                 data_write0,
    output logic                 data_write1,
    output logic                 tag_write0,
    output logic                 tag_write1,
    output logic                 valid_write0,
    output logic                 valid_write1,
    output logic                 dirty_write0,
    output logic                 dirty_write1,
    output logic                 dirty_in,
    output logic                 lru_write,
    output logic                 lru_in,
    output logic                 datain_sel,
    output logic                 pmem_addr_sel,
    output logic                 way_sel,
    input  logic                 perf_clear,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        FETCH     = 2'd3
    } state_t;

    state_t                state_r;
    logic                  victim_r;
    logic                  refill_r;
    logic [CNT_WIDTH-1:0]  hit_count_r;
    logic [CNT_WIDTH-1:0]  miss_count_r;
    logic [CNT_WIDTH-1:0]  wb_count_r;

    logic                  hit_s;
    logic                  hitway_s;
    logic                  lru_dirty_s;
    logic                  hit_inc_s;
    logic                  miss_inc_s;
    logic                  wb_inc_s;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        if (value == {CNT_WIDTH{1'b1}}) begin
            sat_inc = value;
        end else begin
            sat_inc = value + CNT_WIDTH'(1);
        end
    endfunction

    // Way 0 wins if both ways report a hit.
    assign hit_s       = hit0 | hit1;
    assign hitway_s    = hit0 ? 1'b0 : 1'b1;
    assign lru_dirty_s = lru ? dirty1 : dirty0;

    // A re-check after refill completes the request but is not a hit.
    assign hit_inc_s  = (state_r == CHECK) && hit_s && !refill_r;
    assign miss_inc_s = (state_r == CHECK) && !hit_s;
    assign wb_inc_s   = (state_r == WRITEBACK) && pmem_resp;

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
    assign wb_count   = wb_count_r;

    // Array strobes and memory handshake decoded from state and compare results.
    always_comb begin
        l1_resp       = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        data_write0   = 1'b0;
        data_write1   = 1'b0;
        tag_write0    = 1'b0;
        tag_write1    = 1'b0;
        valid_write0  = 1'b0;
        valid_write1  = 1'b0;
        dirty_write0  = 1'b0;
        dirty_write1  = 1'b0;
        dirty_in      = 1'b0;
        lru_write     = 1'b0;
        lru_in        = 1'b0;
        datain_sel    = 1'b0;
        pmem_addr_sel = 1'b0;
        way_sel       = 1'b0;
        case (state_r)
            IDLE: begin
                l1_resp = 1'b0;
            end
            CHECK: begin
                if (hit_s) begin
                    l1_resp   = 1'b1;
                    lru_write = 1'b1;
                    lru_in    = ~hitway_s;
                    if (l1_write) begin
                        data_write0  = ~hitway_s;
                        data_write1  = hitway_s;
                        dirty_write0 = ~hitway_s;
                        dirty_write1 = hitway_s;
                        dirty_in     = 1'b1;
                        datain_sel   = 1'b0;
                    end else begin
                        dirty_in = 1'b0;
                    end
                end else begin
                    l1_resp = 1'b0;
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = victim_r;
            end
            FETCH: begin
                pmem_read     = 1'b1;
                pmem_addr_sel = 1'b0;
                if (pmem_resp) begin
                    data_write0  = ~victim_r;
                    data_write1  = victim_r;
                    tag_write0   = ~victim_r;
                    tag_write1   = victim_r;
                    valid_write0 = ~victim_r;
                    valid_write1 = victim_r;
                    dirty_write0 = ~victim_r;
                    dirty_write1 = victim_r;
                    dirty_in     = 1'b0;
                    datain_sel   = 1'b1;
                end else begin
                    datain_sel = 1'b0;
                end
            end
            default: begin
                l1_resp = 1'b0;
            end
        endcase
    end

    // Control state machine with victim and refill tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            victim_r <= 1'b0;
            refill_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    refill_r <= 1'b0;
                    if (l1_read || l1_write) begin
                        state_r <= CHECK;
                    end
                end
                CHECK: begin
                    if (hit_s) begin
                        state_r <= IDLE;
                    end else begin
                        victim_r <= lru;
                        state_r  <= lru_dirty_s ? WRITEBACK : FETCH;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state_r <= FETCH;
                    end
                end
                FETCH: begin
                    if (pmem_resp) begin
                        refill_r <= 1'b1;
                        state_r  <= CHECK;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Saturating performance counters; clear beats any same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_r  <= {CNT_WIDTH{1'b0}};
            miss_count_r <= {CNT_WIDTH{1'b0}};
            wb_count_r   <= {CNT_WIDTH{1'b0}};
        end else if (perf_clear) begin
            hit_count_r  <= {CNT_WIDTH{1'b0}};
            miss_count_r <= {CNT_WIDTH{1'b0}};
            wb_count_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            if (hit_inc_s)  hit_count_r  <= sat_inc(hit_count_r);
            if (miss_inc_s) miss_count_r <= sat_inc(miss_count_r);
            if (wb_inc_s)   wb_count_r   <= sat_inc(wb_count_r);
        end
    end

endmodule
